// File: rtl/mod12_count_checker.sv
// In-line checker for the mod-12 up/down counter: predicts data_out every cycle,
// resynchronises to the DUT on divergence and counts mismatches and wraps.
module mod12_count_checker #(
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [3:0]       data_in,
    input  logic [3:0]       data_out,
    output logic [3:0]       exp_out,
    output logic             chk_valid,
    output logic             mismatch,
    output logic             illegal_load,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       wrap_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        CHECK,
        RESYNC,
        HALT
    } state_t;

    state_t     state;
    logic       cmp_fail;
    logic       bad_load;
    logic       step_wraps;
    logic [3:0] base;

    function automatic logic [3:0] next_count(input logic [3:0] b, input logic ld,
                                              input logic up, input logic [3:0] din);
        if (ld)
            return din;
        else if (up)
            return (b == 4'd11) ? 4'd0 : b + 4'd1;
        else
            return (b == 4'd0) ? 4'd11 : b - 4'd1;
    endfunction

    assign chk_valid  = (state == CHECK);
    assign halted     = (state == HALT);
    assign cmp_fail   = chk_valid && (data_out != exp_out);
    assign bad_load   = chk_valid && load && (data_in > 4'd11);
    // After a failed compare or an uncompared cycle the DUT's own value becomes the base.
    assign base       = (cmp_fail || state == RESYNC) ? data_out : exp_out;
    assign step_wraps = chk_valid && !cmp_fail && !load &&
                        (mode ? (exp_out == 4'd11) : (exp_out == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CHECK;
            exp_out      <= 4'd0;
            mismatch     <= 1'b0;
            illegal_load <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            wrap_count   <= 8'd0;
        end else begin
            mismatch     <= cmp_fail;
            illegal_load <= bad_load;
            if (cmp_fail) begin
                err_sticky <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + ERR_W'(1);
            end
            if (step_wraps)
                wrap_count <= wrap_count + 8'd1;
            // An illegal load outranks halting: the DUT value is undefined next cycle.
            case (state)
                CHECK: begin
                    if (bad_load) begin
                        exp_out <= data_in;
                        state   <= RESYNC;
                    end else begin
                        exp_out <= next_count(base, load, mode, data_in);
                        state   <= (cmp_fail && STOP_ON_ERR) ? HALT : CHECK;
                    end
                end
                RESYNC: begin
                    exp_out <= next_count(base, load, mode, data_in);
                    state   <= CHECK;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= CHECK;
                end
            endcase
        end
    end

endmodule
